pc_flow_controller: RTL
=======================

// Module: pc_flow_controller
// PURPOSE
//  Sequences the program counter: turns decoded step/jump/call/return requests into
//  the counter-enable, load-enable and load-data controls of the PC.
//  Evaluates jump conditions against the ALU flags.
//  Owns a hardware return-address stack for CALL/RET.
//  Sits between the instruction decoder and the PC; advances on the same clk_en/halt as the PC.
// PARAMETERS
//  WIDTH        16  address width, equals the PC width
//  STACK_DEPTH  4   return-stack entries (>=1); SPW = $clog2(STACK_DEPTH+1)
// PORTS
//  clk                  in   1      system clock
//  rst                  in   1      synchronous, active-high reset
//  clk_en               in   1      global clock enable (shared with the PC)
//  i_halt               in   1      freezes the controller (shared with the PC)
//  i_step               in   1      request: PC+1
//  i_jump               in   1      request: conditional load of i_target
//  i_cond               in   3      000 always, 001 Z, 010 !Z, 011 S, 100 !S; others: never taken
//  i_call               in   1      request: push i_pc, load i_target
//  i_ret                in   1      request: pop return address, load it
//  i_target             in   WIDTH  jump/call destination
//  i_pc                 in   WIDTH  current PC value (the PC's o_data)
//  i_zero, i_sign       in   1      ALU flags
//  o_pc_counter_enable  out  1      to the PC's i_counter_enable
//  o_pc_load_enable     out  1      to the PC's i_load_enable
//  o_pc_load_data       out  WIDTH  to the PC's i_load_data
//  o_busy               out  1      high when not in IDLE; requests are ignored
//  o_fault              out  1      sticky stack overflow/underflow; drives the system halt
//  o_depth              out  SPW    current return-stack occupancy
// BEHAVIOUR
//  Tick = posedge clk with clk_en=1 and i_halt=0.
//  - On a non-tick edge, all state, stack and outputs hold.
//  - rst acts on any posedge clk, regardless of clk_en/i_halt:
//    state=IDLE, sp=0, fault=0, all outputs 0; stack RAM contents are not cleared.
//  - All outputs are registered.
//  FSM states: IDLE, ISSUE, RET_RD, FAULT.
//  IDLE, request priority ret > call > jump > step (only the highest is acted on):
//  - ret:  sp==0 -> FAULT. Else sp<=sp-1 -> RET_RD.
//  - call: sp==STACK_DEPTH -> FAULT, no write. Else stack[sp]<=i_pc+1 (WIDTH wrap),
//    sp<=sp+1, load_en<=1, load_data<=i_target -> ISSUE.
//  - jump taken:     load_en<=1, load_data<=i_target -> ISSUE.
//  - jump not taken: counter_en<=1 -> ISSUE.
//  - step:           counter_en<=1 -> ISSUE.
//  - no request:     stay in IDLE, outputs 0.
//  RET_RD: load_en<=1, load_data<=stack[sp] -> ISSUE.
//  ISSUE: the outputs are valid for exactly this state; the PC samples them on the
//   next tick. That tick clears the outputs -> IDLE.
//  FAULT: o_fault=1, all PC controls 0, sp frozen; left only by rst.
//  Latency (request tick to the PC update tick):
//   step/jump/call = 1 tick; ret = 2 ticks.
//   The next request is accepted on the tick after the PC update.
//  At most one of load_en / counter_en is high at any time.
//  o_busy = (state != IDLE); o_depth = sp. Condition flags are sampled on the accept tick.
// TESTING
//  1. rst, then step held high for 4 ticks -> counter_en pulses on alternate ticks; o_busy toggles.
//  2. jump cond=001, i_zero=0, i_target=0x1234 -> counter_en=1, load_en=0.
//     Repeat with i_zero=1 -> load_en=1, load_data=0x1234.
//  3. call i_pc=0x0010, target=0x0200; then ret -> load 0x0200, o_depth=1;
//     then load 0x0011 two ticks after the ret, o_depth=0.
//  4. STACK_DEPTH+1 nested calls -> the last one sets o_fault=1, no load, o_depth=4.
//     Only rst clears the fault.
//  5. ret with o_depth=0 -> o_fault=1, all PC controls 0.
//  6. call+ret+step together at depth 1 -> ret wins; i_halt or clk_en=0 mid-ret freezes RET_RD.

Source files
------------

// File: rtl/pc_flow_controller.sv
// Program-counter flow controller: turns step/jump/call/return requests into PC
// counter/load controls and keeps a hardware return-address stack.
module pc_flow_controller #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4,
    localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             i_halt,
    input  logic             i_step,
    input  logic             i_jump,
    input  logic [2:0]       i_cond,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_zero,
    input  logic             i_sign,
    output logic             o_pc_counter_enable,
    output logic             o_pc_load_enable,
    output logic [WIDTH-1:0] o_pc_load_data,
    output logic             o_busy,
    output logic             o_fault,
    output logic [SPW-1:0]   o_depth
);

    // state  | meaning
    // IDLE   | waiting for a request, PC controls low
    // ISSUE  | PC controls valid, PC consumes them on the next tick
    // RET_RD | return address being read from the stack
    // FAULT  | stack overflow/underflow, held until reset
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RET_RD = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_t               state_q, state_d;
    logic [SPW-1:0]       sp_q, sp_d;
    logic                 fault_q, fault_d;
    logic                 cnt_en_q, cnt_en_d;
    logic                 ld_en_q, ld_en_d;
    logic [WIDTH-1:0]     ld_data_q, ld_data_d;
    logic [WIDTH-1:0]     stack_q [STACK_DEPTH];
    logic                 push_en;
    logic [WIDTH-1:0]     push_data;
    logic                 tick;
    logic                 cond_ok;

    assign tick = clk_en && !i_halt;

    always_comb begin
        case (i_cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = i_zero;
            3'b010:  cond_ok = !i_zero;
            3'b011:  cond_ok = i_sign;
            3'b100:  cond_ok = !i_sign;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        fault_d   = fault_q;
        cnt_en_d  = cnt_en_q;
        ld_en_d   = ld_en_q;
        ld_data_d = ld_data_q;
        push_en   = 1'b0;
        push_data = i_pc + WIDTH'(1);
        if (tick) begin
            case (state_q)
                IDLE: begin
                    cnt_en_d  = 1'b0;
                    ld_en_d   = 1'b0;
                    ld_data_d = '0;
                    if (i_ret) begin
                        if (sp_q == '0) begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sp_d    = sp_q - SPW'(1);
                            state_d = RET_RD;
                        end
                    end else if (i_call) begin
                        if (sp_q == SPW'(STACK_DEPTH)) begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end else begin
                            push_en   = 1'b1;
                            sp_d      = sp_q + SPW'(1);
                            ld_en_d   = 1'b1;
                            ld_data_d = i_target;
                            state_d   = ISSUE;
                        end
                    end else if (i_jump) begin
                        if (cond_ok) begin
                            ld_en_d   = 1'b1;
                            ld_data_d = i_target;
                        end else begin
                            cnt_en_d = 1'b1;
                        end
                        state_d = ISSUE;
                    end else if (i_step) begin
                        cnt_en_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
                RET_RD: begin
                    // sp was already decremented on accept, so it points at the top entry
                    ld_en_d   = 1'b1;
                    ld_data_d = stack_q[sp_q[AW-1:0]];
                    state_d   = ISSUE;
                end
                ISSUE: begin
                    cnt_en_d  = 1'b0;
                    ld_en_d   = 1'b0;
                    ld_data_d = '0;
                    state_d   = IDLE;
                end
                default: begin
                    cnt_en_d  = 1'b0;
                    ld_en_d   = 1'b0;
                    ld_data_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            fault_q   <= 1'b0;
            cnt_en_q  <= 1'b0;
            ld_en_q   <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            fault_q   <= fault_d;
            cnt_en_q  <= cnt_en_d;
            ld_en_q   <= ld_en_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Stack RAM is deliberately not reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_q[sp_q[AW-1:0]] <= push_data;
        end
    end

    assign o_pc_counter_enable = cnt_en_q;
    assign o_pc_load_enable    = ld_en_q;
    assign o_pc_load_data      = ld_data_q;
    assign o_busy              = (state_q != IDLE);
    assign o_fault             = fault_q;
    assign o_depth             = sp_q;

endmodule
